// File: rtl/pistormx_pkg.sv
// Shared types and constants for the Pi-to-68K transaction path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pistormx_pkg;

    // 68K word-address width, A[23:1]
    localparam int PI_AW = 23;

    // Pi register select codes on PI_A
    localparam logic [1:0] REG_DATA    = 2'd0;
    localparam logic [1:0] REG_ADDR_LO = 2'd1;
    localparam logic [1:0] REG_ADDR_HI = 2'd2;
    localparam logic [1:0] REG_STATUS  = 2'd3;

    // STATUS read word bit positions, and the write-side clear bit
    localparam int ST_OVF_BIT     = 15;
    localparam int ST_FULL_BIT    = 14;
    localparam int ST_EMPTY_BIT   = 13;
    localparam int ST_CLR_OVF_BIT = 2;

    typedef struct packed {
        logic [PI_AW-1:0] a;    // word address A[23:1]
        logic [15:0]      d;    // write data
        logic             rw;   // 1 read, 0 write
        logic             sz;   // 1 byte, 0 word
        logic             a0;   // byte lane: 1 LDS, 0 UDS
    } txn_t;

    // Idle head value: a read with zero address so OP_RW reads 1 out of reset
    localparam txn_t TXN_IDLE = '{a: '0, d: '0, rw: 1'b1, sz: 1'b0, a0: 1'b0};

    function automatic logic [15:0] status_word(input logic       ovf,
                                                input logic       full,
                                                input logic       empty,
                                                input logic [3:0] cnt);
        return {ovf, full, empty, 9'b0, cnt};
    endfunction

endpackage

// File: rtl/pi_wr_sync.sv
// Pi write strobe synchronizer with rising-edge commit pulse and registered A/D capture.
// Latency: commit_vld is high in the cycle after the 2nd clock edge past the strobe edge (state lands on the 3rd).
// Backpressure: none; the Pi must hold PI_A/PI_D_IN at least 3 clocks around the strobe.
// Ports: clk, rst_n, wr_async/a_async/d_async (Pi pins), commit_vld/commit_a/commit_d (core domain).
module pi_wr_sync (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_async,
    input  logic [1:0]  a_async,
    input  logic [15:0] d_async,
    output logic        commit_vld,
    output logic [1:0]  commit_a,
    output logic [15:0] commit_d
);

    logic        wr_s1;
    logic        wr_s2;
    logic        wr_s3;
    logic [1:0]  a_s1;
    logic [15:0] d_s1;

    // Address/data travel through the same two stages as the strobe so that
    // the captured values line up with the commit pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_s1    <= 1'b0;
            wr_s2    <= 1'b0;
            wr_s3    <= 1'b0;
            a_s1     <= '0;
            d_s1     <= '0;
            commit_a <= '0;
            commit_d <= '0;
        end else begin
            wr_s1    <= wr_async;
            wr_s2    <= wr_s1;
            wr_s3    <= wr_s2;
            a_s1     <= a_async;
            d_s1     <= d_async;
            commit_a <= a_s1;
            commit_d <= d_s1;
        end
    end

    assign commit_vld = wr_s2 & ~wr_s3;

endmodule

// File: rtl/pi_txn_queue.sv
// Pi register capture and transaction queue feeding the 68K bus engine.
// Latency: head visible on OP_* in the cycle after the ADDR_HI commit; PI_TXN_IN_PROGRESS follows state by one register.
// Backpressure: OP_VALID/OP_READY handshake; a push into a full queue without a pop is dropped and sets sticky overflow.
// Ports: M68K_CLK/M68K_RESET_n; PI_A/PI_WR/PI_RD/PI_D_IN/PI_D_OUT/PI_D_OE/PI_TXN_IN_PROGRESS (Pi side);
//        OP_VALID/OP_READY/OP_A/OP_D/OP_RW/OP_SZ/OP_A0, RD_DONE/RD_DATA (bus engine side).
// Build option: POST_WRITE_EN -- when defined, writes are posted up to DEPTH deep; otherwise depth is 1.
module pi_txn_queue
    import pistormx_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 23
) (
    input  logic          M68K_CLK,
    input  logic          M68K_RESET_n,
    input  logic [1:0]    PI_A,
    input  logic          PI_WR,
    input  logic          PI_RD,
    input  logic [15:0]   PI_D_IN,
    output logic [15:0]   PI_D_OUT,
    output logic          PI_D_OE,
    output logic          PI_TXN_IN_PROGRESS,
    output logic          OP_VALID,
    input  logic          OP_READY,
    output logic [AW-1:0] OP_A,
    output logic [15:0]   OP_D,
    output logic          OP_RW,
    output logic          OP_SZ,
    output logic          OP_A0,
    input  logic          RD_DONE,
    input  logic [15:0]   RD_DATA
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
`ifdef POST_WRITE_EN
    localparam int EFF_DEPTH = DEPTH;
`else
    localparam int EFF_DEPTH = 1;
`endif
    localparam logic [CW-1:0] EFF_CNT = CW'(EFF_DEPTH);

    logic        commit_vld;
    logic [1:0]  commit_a;
    logic [15:0] commit_d;

    pi_wr_sync u_wr_sync (
        .clk        (M68K_CLK),
        .rst_n      (M68K_RESET_n),
        .wr_async   (PI_WR),
        .a_async    (PI_A),
        .d_async    (PI_D_IN),
        .commit_vld (commit_vld),
        .commit_a   (commit_a),
        .commit_d   (commit_d)
    );

    // Staging: ADDR_HI fields are taken straight from the commit word, so
    // only the DATA and ADDR_LO parts need holding between commits.
    logic [15:0] stage_d;
    logic [14:0] stage_lo;
    logic        stage_a0;

    txn_t          mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;
    logic [CW-1:0] rd_cnt;
    logic [CW-1:0] rd_cnt_nxt;
    logic          overflow;
    logic [15:0]   rd_latch;
    logic          txn_busy;
    logic          txn_nxt;

    txn_t head;
    txn_t push_txn;
    logic push_vld;
    logic push_ok;
    logic pop;
    logic full;
    logic empty;
    logic ovf_set;
    logic ovf_clr;
    logic rd_inc;
    logic rd_dec;

    assign head  = mem[rd_ptr];
    assign full  = (count == EFF_CNT);
    assign empty = (count == '0);

    assign OP_VALID = ~empty;
    assign OP_A     = head.a;
    assign OP_D     = head.d;
    assign OP_RW    = head.rw;
    assign OP_SZ    = head.sz;
    assign OP_A0    = head.a0;

    assign push_vld = commit_vld & (commit_a == REG_ADDR_HI);
    assign pop      = OP_VALID & OP_READY;
    // A pop in the same cycle frees the slot, so a full queue still accepts.
    assign push_ok  = push_vld & (~full | pop);
    assign ovf_set  = push_vld & full & ~pop;
    assign ovf_clr  = commit_vld & (commit_a == REG_STATUS) & commit_d[ST_CLR_OVF_BIT];
    assign rd_inc   = push_ok & push_txn.rw;
    assign rd_dec   = RD_DONE & (rd_cnt != '0);

    always_comb begin
        push_txn    = TXN_IDLE;
        push_txn.a  = {commit_d[7:0], stage_lo};
        push_txn.d  = stage_d;
        push_txn.rw = commit_d[9];
        push_txn.sz = commit_d[8];
        push_txn.a0 = stage_a0;
    end

    always_comb begin
        count_nxt = count;
        case ({push_ok, pop})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
        rd_cnt_nxt = rd_cnt;
        case ({rd_inc, rd_dec})
            2'b10:   rd_cnt_nxt = rd_cnt + CW'(1);
            2'b01:   rd_cnt_nxt = rd_cnt - CW'(1);
            default: rd_cnt_nxt = rd_cnt;
        endcase
        // Evaluated on next-state values so the registered flag tracks the
        // queue one cycle after the event that changes it.
`ifdef POST_WRITE_EN
        txn_nxt = (count_nxt == EFF_CNT) | (rd_cnt_nxt != '0);
`else
        txn_nxt = (count_nxt != '0) | (rd_cnt_nxt != '0);
`endif
    end

    always_ff @(posedge M68K_CLK or negedge M68K_RESET_n) begin
        if (!M68K_RESET_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= TXN_IDLE;
            end
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            rd_cnt   <= '0;
            overflow <= 1'b0;
            stage_d  <= '0;
            stage_lo <= '0;
            stage_a0 <= 1'b0;
            rd_latch <= '0;
            txn_busy <= 1'b0;
        end else begin
            if (commit_vld) begin
                case (commit_a)
                    REG_DATA: stage_d <= commit_d;
                    REG_ADDR_LO: begin
                        stage_lo <= commit_d[15:1];
                        stage_a0 <= commit_d[0];
                    end
                    default: ;
                endcase
            end
            if (push_ok) begin
                mem[wr_ptr] <= push_txn;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count  <= count_nxt;
            rd_cnt <= rd_cnt_nxt;
            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
            if (RD_DONE) begin
                rd_latch <= RD_DATA;
            end
            txn_busy <= txn_nxt;
        end
    end

    assign PI_TXN_IN_PROGRESS = txn_busy;

    // Pi read mux is purely combinational on the pins.
    assign PI_D_OE  = PI_RD & ((PI_A == REG_DATA) | (PI_A == REG_STATUS));
    assign PI_D_OUT = (PI_A == REG_STATUS) ? status_word(overflow, full, empty, 4'(count))
                                           : rd_latch;

endmodule

// File: doc/pi_txn_queue.md
Name: pi_txn_queue

Overview:
- Upstream feeder for the 68K bus transfer state machine.
- Captures Pi GPIO register writes (data, address lo, address hi/command) in the M68K_CLK domain and queues complete transactions in a small FIFO. Write transactions are posted.
- Presents one transaction at a time to the bus engine with a valid/ready handshake, returns read data, and drives PI_TXN_IN_PROGRESS and the Pi-side read mux.

Parameters:
DEPTH, 4, number of queued transactions; power of two, 2..8.
AW, 23, 68K word-address width (A[23:1]).

Ports:
M68K_CLK  in  1  sole clock (7 MHz 68K clock); all state on rising edge.
M68K_RESET_n  in  1  asynchronous active-low reset.
PI_A  in  2  Pi register select: 0 DATA, 1 ADDR_LO, 2 ADDR_HI, 3 STATUS.
PI_WR  in  1  Pi write strobe, asynchronous to M68K_CLK.
PI_RD  in  1  Pi read strobe, asynchronous.
PI_D_IN  in  16  Pi data bus input.
PI_D_OUT  out  16  Pi read data.
PI_D_OE  out  1  Pi data bus output enable.
PI_TXN_IN_PROGRESS  out  1  Pi must not issue a new ADDR_HI while high.
OP_VALID  out  1  head transaction available to the bus engine.
OP_READY  in  1  bus engine accepts head; pop when OP_VALID and OP_READY.
OP_A  out  AW  head address.
OP_D  out  16  head write data.
OP_RW  out  1  1 read, 0 write.
OP_SZ  out  1  1 byte, 0 word.
OP_A0  out  1  byte lane select (1 LDS, 0 UDS).
RD_DONE  in  1  one-cycle pulse when a read bus cycle has latched data.
RD_DATA  in  16  read data, valid with RD_DONE.

Behaviour:
- Sync: PI_WR passes through a 2-flop synchronizer, and PI_A and PI_D_IN are registered alongside it. A rising edge of the synchronized PI_WR is a commit, occurring on the 3rd clock edge after the pin edge. PI_A and PI_D_IN must be held ≥3 clocks.
- Commit DATA: stage_d <= D.
- Commit ADDR_LO: stage_a[15:1] <= D[15:1]; stage_a0 <= D[0].
- Commit ADDR_HI: {stage_a[23:16], sz, rw} from D[7:0], D[8], D[9]. Pushes {stage_a, stage_d, rw, sz, a0} into the FIFO in the same cycle; the pushed entry uses the new ADDR_HI fields.
- Commit STATUS: D[2]=1 clears overflow. Other bits are ignored.
- FIFO: wr_ptr, rd_ptr and count (width clog2(DEPTH)+1); pointers wrap modulo DEPTH. OP_* come from the head entry combinationally, and OP_VALID = (count≠0).
- Push when full and no pop: entry dropped, sticky overflow <= 1.
- Push and pop in the same cycle: both occur, count unchanged, including at full and at count=1.
- Read tracking: rd_pending sets when a read entry is pushed and clears on RD_DONE. On RD_DONE, rd_latch <= RD_DATA.
- A second read push while rd_pending is legal; rd_pending stays set until the last RD_DONE. Count reads with a counter of width clog2(DEPTH)+1.
- Ordering is strictly FIFO.
- PI_TXN_IN_PROGRESS = full | (rd_cnt≠0), registered. It rises the cycle after the push that causes it.
- Pi read mux (combinational, no sync):
  - PI_D_OE = PI_RD & (PI_A==0 | PI_A==3).
  - PI_A==0 returns rd_latch.
  - PI_A==3 returns {overflow, full, empty, 9'b0, count[3:0]}, with count zero-extended to 4 bits.
- Reset: FIFO empty, count=0, rd_cnt=0, overflow=0, staging regs=0, rd_latch=0, sync flops=0. Outputs: OP_VALID=0, PI_TXN_IN_PROGRESS=0, PI_D_OE=0, OP_RW=1.
- Reset mid-transfer discards all queued entries. A held OP_READY does not pop after reset.

Optional Feature:
POST_WRITE_EN:
- Defined: behaviour as above; writes are posted up to DEPTH deep.
- Undefined: effective depth 1. PI_TXN_IN_PROGRESS = OP_VALID | (rd_cnt≠0), so every transaction blocks the Pi until popped, or for reads until RD_DONE. The overflow path remains.

Decomposition:
- Package pistormx_pkg:
  - Register index constants REG_DATA/REG_ADDR_LO/REG_ADDR_HI/REG_STATUS.
  - Struct txn_t {a, d, rw, sz, a0}.
  - STATUS bit positions.
- Sub-module pi_wr_sync: 2-flop synchronizer plus rising-edge detect with registered address/data capture.

Test Plan:
- Write DATA=0x1234, ADDR_LO=0x5679, ADDR_HI=0x00FC (rw=0, sz=0) -> OP_VALID high ≤1 cycle after commit, OP_A=0xFC5678 (A[23:1]), OP_A0=1, OP_D=0x1234, OP_RW=0; TXN stays 0.
- Push 4 writes with OP_READY=0 -> count=4, TXN=1, STATUS=0x4004. A 5th push sets overflow (STATUS bit15) and head is unchanged. Write STATUS D[2]=1 -> overflow clears.
- Read ADDR_HI=0x0200 -> TXN=1 until RD_DONE with RD_DATA=0xBEEF. TXN falls next cycle, and a Pi read of DATA returns 0xBEEF with PI_D_OE=1.
- count=4 with simultaneous push and pop -> count stays 4, no overflow, and new entry emerges 4 pops later.
- Assert M68K_RESET_n=0 with 3 queued entries and rd_pending -> OP_VALID=0, TXN=0, STATUS=0x2000 immediately (asynchronous).
- POST_WRITE_EN undefined: single write -> TXN=1 until OP_READY pop; second ADDR_HI held off by bench.
